fetch_unit: RTL and testbench

//  Instruction fetch stage; sits directly upstream of decode. Owns the word-indexed PC and drives
//  the synchronous-read instruction BRAM (1-cycle read latency). Presents instr_code/D_pc to decode.

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the word-indexed PC, drives a 1-cycle-latency instruction BRAM
// and presents instr_code/D_pc to decode, inserting NOP bubbles on boot and redirect.
module fetch_unit #(
  parameter int unsigned                 INSTR_ADDR_WIDTH = 14,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        f_en,
  input  logic                        redirect,
  input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
  input  logic                        halt,
  output logic                        imem_en,
  output logic [INSTR_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                 imem_rdata,
  output logic [31:0]                 instr_code,
  output logic [INSTR_ADDR_WIDTH-1:0] D_pc,
  output logic                        instr_valid,
  output logic [31:0]                 fetch_count
);

  localparam logic [31:0]                 NOP_INSTR = 32'h0000_0013;
  localparam logic [INSTR_ADDR_WIDTH-1:0] PC_ONE    = {{(INSTR_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [INSTR_ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [INSTR_ADDR_WIDTH-1:0]   tgt_q, tgt_d;
  logic [31:0]                   fetch_count_q, fetch_count_d;

  // Next-state, PC/target/count update and BRAM request generation.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    fetch_count_d = fetch_count_q;
    imem_en       = 1'b0;
    imem_addr     = pc_q;

    case (state_q)
      ST_BOOT: begin
        if (redirect) begin
          tgt_d   = redirect_pc;
          state_d = ST_REDIR;
        end else if (halt) begin
          state_d = ST_HALT;
        end else begin
          imem_en   = 1'b1;
          imem_addr = RESET_PC;
          pc_d      = RESET_PC;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // The instruction on the outputs this cycle is wrong-path on redirect; decode kills it.
        if (redirect) begin
          tgt_d   = redirect_pc;
          state_d = ST_REDIR;
        end else if (halt) begin
          state_d = ST_HALT;
        end else if (f_en) begin
          imem_en       = 1'b1;
          imem_addr     = pc_q + PC_ONE;
          pc_d          = pc_q + PC_ONE;
          fetch_count_d = fetch_count_q + 32'd1;
        end else begin
          imem_en   = 1'b1;
          imem_addr = pc_q;
        end
      end
      ST_REDIR: begin
        if (redirect) begin
          tgt_d = redirect_pc;
        end else if (halt) begin
          state_d = ST_HALT;
        end else begin
          imem_en   = 1'b1;
          imem_addr = tgt_q;
          pc_d      = tgt_q;
          state_d   = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (!rst_n) begin
      imem_en = 1'b0;
    end else begin
      imem_en = imem_en;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      tgt_q         <= '0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      tgt_q         <= tgt_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign instr_valid = (state_q == ST_RUN);
  assign instr_code  = instr_valid ? imem_rdata : NOP_INSTR;
  assign D_pc        = pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written corner sequences and
// random stimulus, all compared against a cycle-level behavioural model of the fetch stage.
module tb_fetch_unit;
  localparam int IAW = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic           clk = 1'b0;
  logic           rst_n, f_en, redirect, halt;
  logic [IAW-1:0] redirect_pc;
  logic           imem_en;
  logic [IAW-1:0] imem_addr;
  logic [31:0]    imem_rdata;
  logic [31:0]    instr_code;
  logic [IAW-1:0] D_pc;
  logic           instr_valid;
  logic [31:0]    fetch_count;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.INSTR_ADDR_WIDTH(IAW)) dut (
    .clk(clk), .rst_n(rst_n), .f_en(f_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_code(instr_code), .D_pc(D_pc), .instr_valid(instr_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [IAW-1:0] a);
    return 32'h0000_0100 + {24'd0, a};
  endfunction

  // Instruction BRAM: one-cycle registered read.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= memval(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: either presenting the instruction at m_pc, or in a bubble whose next
  // fetch comes from m_next, or halted.
  bit      m_halted, m_bubble;
  int      m_pc, m_next;
  longint  m_count;
  logic           s_valid, s_en;
  logic [IAW-1:0] s_pc, s_addr;

  task automatic model_reset();
    m_halted = 1'b0; m_bubble = 1'b1; m_pc = 0; m_next = 0; m_count = 0;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0; f_en = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
  endtask

  task automatic step(input logic r, input logic f, input logic rd, input logic [IAW-1:0] rp,
                      input logic h);
    bit e_valid, e_en;
    int e_addr;
    rst_n = r; f_en = f; redirect = rd; redirect_pc = rp; halt = h;
    #2;
    e_valid = !m_halted && !m_bubble;
    if (!r || m_halted || rd || h) e_en = 1'b0;
    else e_en = 1'b1;
    if (m_bubble) e_addr = m_next;
    else e_addr = f ? (m_pc + 1) % (1 << IAW) : m_pc;
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
    chk("D_pc", {24'd0, D_pc}, m_pc);
    chk("instr_code", instr_code, e_valid ? memval(IAW'(m_pc)) : NOP);
    chk("fetch_count", fetch_count, m_count[31:0]);
    chk("imem_en", {31'd0, imem_en}, {31'd0, e_en});
    if (e_en) chk("imem_addr", {24'd0, imem_addr}, e_addr);
    s_valid = instr_valid; s_pc = D_pc; s_en = imem_en; s_addr = imem_addr;
    @(posedge clk); #1;
    if (!r) model_reset();
    else if (m_halted) ;
    else if (m_bubble) begin
      if (rd) m_next = rp;
      else if (h) m_halted = 1'b1;
      else begin m_pc = m_next; m_bubble = 1'b0; end
    end else begin
      if (rd) begin m_bubble = 1'b1; m_next = rp; end
      else if (h) m_halted = 1'b1;
      else if (f) begin m_pc = (m_pc + 1) % (1 << IAW); m_count++; end
    end
  endtask

  typedef struct {
    logic r, f, rd; logic [7:0] rp; logic h;
    logic e_valid; logic [7:0] e_pc; logic e_en; logic [7:0] e_addr; logic [31:0] e_cnt;
  } vec_t;

  initial begin
    vec_t vecs[12];
    bit seen40, seen80_first, seen_wrap;
    int guard;
    vecs[0]  = '{1'b0,1'b1,1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0,8'h00,32'd0};
    vecs[1]  = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b0,8'h00,1'b1,8'h00,32'd0};
    vecs[2]  = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b1,8'h00,1'b1,8'h01,32'd0};
    vecs[3]  = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b1,8'h01,1'b1,8'h02,32'd1};
    vecs[4]  = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b1,8'h02,1'b1,8'h03,32'd2};
    vecs[5]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,8'h03,1'b1,8'h03,32'd3};
    vecs[6]  = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b1,8'h03,1'b1,8'h04,32'd3};
    vecs[7]  = '{1'b1,1'b1,1'b1,8'h40,1'b0, 1'b1,8'h04,1'b0,8'h00,32'd4};
    vecs[8]  = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b0,8'h04,1'b1,8'h40,32'd4};
    vecs[9]  = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b1,8'h40,1'b1,8'h41,32'd4};
    vecs[10] = '{1'b1,1'b1,1'b0,8'h00,1'b1, 1'b1,8'h41,1'b0,8'h00,32'd5};
    vecs[11] = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b0,8'h41,1'b0,8'h00,32'd5};

    hard_reset();
    for (int i = 0; i < 12; i++) begin
      rst_n = vecs[i].r; f_en = vecs[i].f; redirect = vecs[i].rd;
      redirect_pc = vecs[i].rp; halt = vecs[i].h;
      #2;
      chk("tbl_valid", {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
      chk("tbl_D_pc", {24'd0, D_pc}, {24'd0, vecs[i].e_pc});
      chk("tbl_instr", instr_code, vecs[i].e_valid ? 32'h100 + {24'd0, vecs[i].e_pc} : NOP);
      chk("tbl_count", fetch_count, vecs[i].e_cnt);
      chk("tbl_en", {31'd0, imem_en}, {31'd0, vecs[i].e_en});
      if (vecs[i].e_en) chk("tbl_addr", {24'd0, imem_addr}, {24'd0, vecs[i].e_addr});
      @(posedge clk); #1;
    end

    // Stall three cycles at D_pc=5, then resume.
    hard_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("stall_pc", {24'd0, s_pc}, 32'd5);
      chk("stall_addr", {24'd0, s_addr}, 32'd5);
    end
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("resume_pc", {24'd0, s_pc}, 32'd6);

    // Back-to-back redirects: newest target wins, first never becomes valid.
    step(1'b1, 1'b1, 1'b1, 8'h40, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h80, 1'b0);
    seen40 = 1'b0; seen80_first = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      if (s_valid && s_pc == 8'h40) seen40 = 1'b1;
      if (i == 1 && s_valid && s_pc == 8'h80) seen80_first = 1'b1;
    end
    chk("redir_old_never_valid", {31'd0, seen40}, 32'd0);
    chk("redir_new_first", {31'd0, seen80_first}, 32'd1);

    // PC wrap at the top of the address space.
    step(1'b1, 1'b1, 1'b1, 8'hFE, 1'b0);
    seen_wrap = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      if (i == 3 && s_valid && s_pc == 8'h00) seen_wrap = 1'b1;
    end
    chk("pc_wrap", {31'd0, seen_wrap}, 32'd1);

    // Reset mid-stream at D_pc=0x23.
    step(1'b1, 1'b1, 1'b1, 8'h20, 1'b0);
    guard = 0;
    while (!(m_pc == 'h23 && !m_bubble) && guard < 20) begin
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      guard++;
    end
    chk("reach_0x23_timeout", guard, (guard < 20) ? guard : 0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_count", fetch_count, 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_pc", {24'd0, s_pc}, 32'd0);

    // Halt is sticky until reset.
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      chk("halt_en", {31'd0, s_en}, 32'd0);
    end

    // Randomized traffic against the model.
    hard_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0),
           8'($urandom),
           ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
